// File: rtl/reaction_round_ctrl_pkg.sv
// Shared encodings for the reaction game round controller: FSM states, winner codes, LFSR constants.
package reaction_round_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    GO     = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_A    = 2'd1,
    W_B    = 2'd2,
    W_TIE  = 2'd3
  } winner_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 of a left-shifting Fibonacci register map onto bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/reaction_round_ctrl_btn_debounce.sv
// Button filter: output follows the raw input only after DEB_CYCLES consecutive stable samples.
// One input register plus the stability count gives DEB_CYCLES+1 cycles of latency.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             raw_q;
  logic             btn_q, btn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count only while the sampled input disagrees with the filtered value; any agreement restarts it.
  always_comb begin
    cnt_d = '0;
    btn_d = btn_q;
    if (raw_q != btn_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        btn_d = raw_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_q <= 1'b0;
      btn_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      raw_q <= btn_i;
      btn_q <= btn_d;
      cnt_q <= cnt_d;
    end
  end

  assign btn_o = btn_q;

endmodule

// File: rtl/reaction_round_ctrl.sv
// Round sequencer and first-press arbiter for the two-player LED reaction game.
// Optional button debounce filter enabled by defining DEBOUNCE_EN.
module reaction_round_ctrl
  import reaction_round_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS  = 5,
  parameter int MIN_DELAY   = 16,
  parameter int GO_TIMEOUT  = 64,
  parameter int HOLD_CYCLES = 8,
  parameter int DEB_CYCLES  = 4
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       BotonA,
  input  logic       BotonB,
  output logic       LedRED,
  output logic       LedVerde,
  output logic       LedFin,
  output logic [1:0] winner,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [3:0] round_cnt
);

  localparam int DLY_W  = $clog2(MIN_DELAY + 16) + 1;
  localparam int TMO_W  = $clog2(GO_TIMEOUT + 1) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1) + 1;

  state_e            state_q, state_d;
  logic [7:0]        lfsr_q;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  winner_e           winner_q, winner_d;
  logic [3:0]        score_a_q, score_a_d;
  logic [3:0]        score_b_q, score_b_d;
  logic [3:0]        round_q, round_d;
  logic [3:0]        round_inc;
  logic              btn_a, btn_b;
  logic              btn_a_q, btn_b_q, start_q;
  logic              press_a, press_b, start_rise;
  logic [DLY_W-1:0]  fresh_dly;

`ifdef DEBOUNCE_EN
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk_i (clock),
    .rst_i (Reset),
    .btn_i (BotonA),
    .btn_o (btn_a)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk_i (clock),
    .rst_i (Reset),
    .btn_i (BotonB),
    .btn_o (btn_b)
  );
`else
  assign btn_a = BotonA;
  assign btn_b = BotonB;
`endif

  assign press_a    = btn_a & ~btn_a_q;
  assign press_b    = btn_b & ~btn_b_q;
  assign start_rise = Start & ~start_q;
  assign fresh_dly  = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q[3:0]);
  assign round_inc  = round_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    tmo_d     = tmo_q;
    hold_d    = hold_q;
    winner_d  = winner_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    round_d   = round_q;
    LedRED    = 1'b0;
    LedVerde  = 1'b0;
    LedFin    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = WAIT;
          dly_d   = fresh_dly;
        end
      end

      // A press before green is a foul: the opponent takes the point.
      WAIT: begin
        LedRED = 1'b1;
        dly_d  = dly_q - DLY_W'(1);
        if (press_a || press_b) begin
          state_d = RESULT;
          hold_d  = HOLD_W'(HOLD_CYCLES);
          if (press_a && press_b) begin
            winner_d = W_TIE;
          end else if (press_a) begin
            winner_d  = W_B;
            score_b_d = sat_inc(score_b_q);
          end else begin
            winner_d  = W_A;
            score_a_d = sat_inc(score_a_q);
          end
        end else if (dly_q <= DLY_W'(1)) begin
          state_d = GO;
          tmo_d   = TMO_W'(GO_TIMEOUT);
        end
      end

      // Presses are checked before the timeout so a last-cycle press still counts.
      GO: begin
        LedVerde = 1'b1;
        tmo_d    = tmo_q - TMO_W'(1);
        if (press_a || press_b) begin
          state_d = RESULT;
          hold_d  = HOLD_W'(HOLD_CYCLES);
          if (press_a && press_b) begin
            winner_d = W_TIE;
          end else if (press_a) begin
            winner_d  = W_A;
            score_a_d = sat_inc(score_a_q);
          end else begin
            winner_d  = W_B;
            score_b_d = sat_inc(score_b_q);
          end
        end else if (tmo_q <= TMO_W'(1)) begin
          state_d  = RESULT;
          hold_d   = HOLD_W'(HOLD_CYCLES);
          winner_d = W_NONE;
        end
      end

      RESULT: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q <= HOLD_W'(1)) begin
          round_d = round_inc;
          if (round_inc == 4'(NUM_ROUNDS)) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            dly_d   = fresh_dly;
          end
        end
      end

      // Only a fresh Start edge restarts; a level held across DONE entry is ignored.
      DONE: begin
        LedFin = 1'b1;
        if (start_rise) begin
          state_d   = WAIT;
          dly_d     = fresh_dly;
          winner_d  = W_NONE;
          score_a_d = 4'd0;
          score_b_d = 4'd0;
          round_d   = 4'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      dly_q     <= '0;
      tmo_q     <= '0;
      hold_q    <= '0;
      winner_q  <= W_NONE;
      score_a_q <= 4'd0;
      score_b_q <= 4'd0;
      round_q   <= 4'd0;
      btn_a_q   <= 1'b0;
      btn_b_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_step(lfsr_q);
      dly_q     <= dly_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      winner_q  <= winner_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      round_q   <= round_d;
      btn_a_q   <= btn_a;
      btn_b_q   <= btn_b;
      start_q   <= Start;
    end
  end

  assign winner    = winner_q;
  assign score_a   = score_a_q;
  assign score_b   = score_b_q;
  assign round_cnt = round_q;

endmodule
